pio_key_debounce: RTL and testbench
===================================

// Module: pio_key_debounce
// PURPOSE
//  Parametrised Avalon-MM input PIO for push-buttons/switches: WIDTH channels, each with a 2-FF synchroniser and debounce counter.
//  Per-bit edge capture with a selectable edge mode, write-1-to-clear, and a per-bit IRQ mask.
//  Sits between the board KEY/SW pins and the Nios II data bus; drives one IRQ line.
// PARAMETERS
//  WIDTH      4   number of input channels, 1..32
//  DB_CYCLES  8   stable cycles required before a debounced bit changes, >=1
//  RESET_VAL  0   reset value of the debounced and synchroniser state (WIDTH bits)
// PORTS
//  clk         in   1      system clock; single clock domain
//  reset       in   1      synchronous, active-high reset
//  address     in   3      register word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data; bits above WIDTH ignored
//  in_port     in   WIDTH  raw asynchronous pin inputs
//  readdata    out  32     registered read data; bits above WIDTH read 0
//  irq         out  1      level interrupt
// BEHAVIOUR
//  Reset (synchronous, clk edge with reset=1):
//   - sync1, sync2 and stable <= RESET_VAL; counters <= 0; irq_mask <= 0; edge_capture <= 0
//   - edge_mode <= 2'b00; readdata <= 0. irq is therefore 0 on the first cycle after reset.
//  Synchroniser: sync1 <= in_port; sync2 <= sync1.
//  Debounce, per bit i, evaluated every clk edge:
//   - sync2[i]==stable[i]: cnt[i] <= 0
//   - else if cnt[i]==DB_CYCLES-1: stable[i] <= sync2[i]; cnt[i] <= 0; raise chg[i] for this edge
//   - else: cnt[i] <= cnt[i]+1
//   - A pin step applied before edge 1 updates stable at edge 2+DB_CYCLES.
//   - A pulse shorter than DB_CYCLES cycles at sync2 is dropped and its counter restarts from 0.
//  Edge qualify: evt[i] = chg[i] & mode_hit(new stable[i]).
//   - edge_mode 00: any change; 01: rising only; 10: falling only; 11: capture disabled.
//  edge_capture[i], same clk edge as evt:
//   - set if evt[i]
//   - else cleared if writing address 4 with writedata[i]=1 (W1C)
//   - set wins over a simultaneous clear; bits written 0 are unaffected
//  irq = |(edge_capture & irq_mask), combinational from registers; no extra latency.
//  Register map (word address); writes require chipselect=1 and write_n=0:
//   - 0 DATA     RO  debounced stable value
//   - 1 RAW      RO  sync2 (synchronised, not debounced)
//   - 2 IRQMASK  RW  per-bit interrupt enable
//   - 3 MODE     RW  edge_mode in bits [1:0]
//   - 4 EDGECAP  RW1C  captured edges
//   - 5..7 read 0, writes ignored
//  Read: readdata <= mux(address) on every clk edge, independent of chipselect; fixed read latency 1.
//  Width: cnt is $clog2(DB_CYCLES+1) bits and never exceeds DB_CYCLES-1. No wrap-around is reachable.
//  MODE write: takes effect for events on the following edge; edge_capture bits already set are retained.
//  IRQMASK write: affects irq on the next cycle; edge_capture is unchanged.
//  Reset mid-debounce: the partial count is discarded and no event is generated from it.
// STRUCTURE
//  Shared package pio_key_pkg:
//   - register address localparams (ADDR_DATA..ADDR_EDGECAP)
//   - edge-mode encoding (EM_ANY, EM_RISE, EM_FALL, EM_OFF)
//  Sub-module key_debounce_ch: one channel containing sync1/sync2, counter, stable bit and chg pulse; instantiated WIDTH times.
//  Top level holds the register file, edge qualification, edge_capture, IRQ and the read mux.
// TESTING (WIDTH=4, DB_CYCLES=8)
//  1 Reset with in_port=4'hF -> DATA reads 0 initially. DATA=4'hF from edge 10 onward; with mode=00, EDGECAP=4'hF.
//  2 in_port[0] pulse high for 5 cycles -> DATA[0] stays 0, EDGECAP stays 0. A 12-cycle pulse -> DATA[0] rises, then falls, EDGECAP[0]=1.
//  3 MODE=01, IRQMASK=4'h2, in_port[1] goes 0->1 -> irq=1 from edge 10. Writing EDGECAP=4'h2 drops irq next cycle; a 1->0 change then leaves irq=0.
//  4 Set evt[2] on the same edge as an EDGECAP write of 4'h4 -> EDGECAP[2]=1 (set wins). Writing 4'h0 leaves all bits unchanged.
//  5 MODE=11 with toggling inputs -> DATA tracks the inputs, EDGECAP stays 0, irq stays 0. Reads at addresses 5..7 return 0.
//  6 Assert reset at count 5 of a debounce -> cnt=0, DATA=RESET_VAL, IRQMASK=0, and no event is produced from the partial count.

Source files
------------

// File: rtl/pio_key_pkg.sv
// Shared definitions for the push-button/switch input PIO: register map,
// edge-mode encoding and the bus request bundle.
package pio_key_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_EDGECAP = 3'd4;

  typedef enum logic [1:0] {
    EM_ANY  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_OFF  = 2'b11
  } edge_mode_e;

  typedef struct packed {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
  } bus_req_t;

  // True when a debounced transition to new_val should be captured under mode m.
  function automatic logic mode_hit(input edge_mode_e m, input logic new_val);
    case (m)
      EM_ANY:  return 1'b1;
      EM_RISE: return new_val;
      EM_FALL: return ~new_val;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One input channel: 2-FF synchroniser, stability counter and debounced bit.
// chg_o pulses combinationally on the edge where the debounced bit flips.
module key_debounce_ch
  import pio_key_pkg::*;
#(
  parameter int   DB_CYCLES = 8,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic raw_o,
  output logic stable_o,
  output logic chg_o
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg;

  // Counter only runs while the synchronised pin disagrees with the
  // debounced value; any agreement restarts the window from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    chg      = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        chg      = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign raw_o    = sync2_q;
  assign stable_o = stable_q;
  assign chg_o    = chg;

endmodule

// File: rtl/pio_key_debounce.sv
// Avalon-MM input PIO for keys/switches: per-channel debounce, edge capture
// with selectable edge mode, W1C capture register and masked level IRQ.
module pio_key_debounce
  import pio_key_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DB_CYCLES = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  bus_req_t         req;
  logic [WIDTH-1:0] raw, stable, chg, evt, w1c;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  edge_mode_e       mode_q, mode_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wdata;

  assign req = '{addr: address, wr: chipselect & ~write_n, wdata: writedata};
  assign unused_wdata = &{1'b0, req.wdata};

  // A channel's chg pulse means its stable bit becomes raw on this edge,
  // so raw is the new debounced value for edge qualification.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .RESET_VAL (RESET_VAL[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pin_i    (in_port[i]),
      .raw_o    (raw[i]),
      .stable_o (stable[i]),
      .chg_o    (chg[i])
    );
    assign evt[i] = chg[i] & mode_hit(mode_q, raw[i]);
  end

  always_comb begin
    irq_mask_d = irq_mask_q;
    mode_d     = mode_q;
    w1c        = '0;
    if (req.wr) begin
      case (req.addr)
        ADDR_IRQMASK: irq_mask_d = req.wdata[WIDTH-1:0];
        ADDR_MODE:    mode_d     = edge_mode_e'(req.wdata[1:0]);
        ADDR_EDGECAP: w1c        = req.wdata[WIDTH-1:0];
        default:      ;
      endcase
    end
    // New events override a simultaneous clear of the same bit.
    edge_cap_d = (edge_cap_q & ~w1c) | evt;
  end

  always_comb begin
    readdata_d = '0;
    case (req.addr)
      ADDR_DATA:    readdata_d = 32'(stable);
      ADDR_RAW:     readdata_d = 32'(raw);
      ADDR_IRQMASK: readdata_d = 32'(irq_mask_q);
      ADDR_MODE:    readdata_d = 32'(mode_q);
      ADDR_EDGECAP: readdata_d = 32'(edge_cap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q <= '0;
      mode_q     <= EM_ANY;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      mode_q     <= mode_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_key_debounce.sv
// Directed bench for pio_key_debounce with a sliding-window reference model
// checked every cycle, plus hand-computed timing checkpoints.
module tb_pio_key_debounce;

  localparam int W  = 4;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   readdata;
  logic          irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pio_key_debounce #(.WIDTH(W), .DB_CYCLES(DB), .RESET_VAL('0)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: pin delayed two samples; a debounced bit takes a new
  // value once the last DB sampled values all agree on it.
  logic [W-1:0] m_p1, m_p2, m_stable, m_mask, m_ec;
  logic [1:0]   m_mode;
  logic [31:0]  m_rd;
  bit           m_valid = 0;
  logic [W-1:0] m_win[$];

  always @(posedge clk) begin : model
    logic [W-1:0] evt;
    bit same;
    if (reset) begin
      m_p1 = '0; m_p2 = '0; m_stable = '0; m_mask = '0; m_ec = '0;
      m_mode = 2'b00; m_rd = '0; m_win.delete(); m_valid = 1;
    end else begin
      case (address)
        3'd0:    m_rd = 32'(m_stable);
        3'd1:    m_rd = 32'(m_p2);
        3'd2:    m_rd = 32'(m_mask);
        3'd3:    m_rd = 32'(m_mode);
        3'd4:    m_rd = 32'(m_ec);
        default: m_rd = '0;
      endcase
      m_win.push_back(m_p2);
      if (m_win.size() > DB) void'(m_win.pop_front());
      evt = '0;
      if (m_win.size() == DB) begin
        for (int i = 0; i < W; i++) begin
          same = 1;
          foreach (m_win[j]) if (m_win[j][i] != m_p2[i]) same = 0;
          if (same && (m_p2[i] != m_stable[i])) begin
            m_stable[i] = m_p2[i];
            if (m_mode == 2'b00 || (m_mode == 2'b01 && m_p2[i]) || (m_mode == 2'b10 && !m_p2[i]))
              evt[i] = 1'b1;
          end
        end
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd2:    m_mask = writedata[W-1:0];
          3'd3:    m_mode = writedata[1:0];
          3'd4:    m_ec   = m_ec & ~writedata[W-1:0];
          default: ;
        endcase
      end
      m_ec = m_ec | evt;
      m_p2 = m_p1;
      m_p1 = in_port;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_readdata", readdata, m_rd);
      chk("model_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a;
    @(negedge clk);
    v = readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    // 1: reset with all pins high, then debounce from RESET_VAL
    in_port = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0; address = 3'd0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1)  chk("s1_data_init", readdata, 32'h0);
      if (k == 10) chk("s1_data_e10", readdata, 32'h0);
      if (k == 11) chk("s1_data_e11", readdata, 32'hF);
    end
    rd(3'd4, v); chk("s1_edgecap", v, 32'hF);
    wr(3'd4, 32'hF); rd(3'd4, v); chk("s1_w1c", v, 32'h0);

    // 2: short pulse dropped, long pulse captured
    in_port = 4'h0; repeat (12) @(negedge clk);
    wr(3'd4, 32'hF);
    address = 3'd0; in_port = 4'h1;
    repeat (5) @(negedge clk);
    in_port = 4'h0;
    repeat (12) @(negedge clk);
    chk("s2_short_data", readdata, 32'h0);
    rd(3'd4, v); chk("s2_short_ec", v, 32'h0);
    address = 3'd0; in_port = 4'h1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 11) chk("s2_long_rise", readdata, 32'h1);
    end
    in_port = 4'h0;
    repeat (12) @(negedge clk);
    chk("s2_long_fall", readdata, 32'h0);
    rd(3'd4, v); chk("s2_long_ec", v, 32'h1);
    wr(3'd4, 32'hF);

    // 3: rising-only capture with mask on bit 1
    wr(3'd3, 32'h1); wr(3'd2, 32'h2);
    in_port = 4'h2;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9)  chk("s3_irq_e9", {31'b0, irq}, 32'h0);
      if (k == 10) chk("s3_irq_e10", {31'b0, irq}, 32'h1);
    end
    wr(3'd4, 32'h2);
    chk("s3_irq_cleared", {31'b0, irq}, 32'h0);
    in_port = 4'h0; repeat (12) @(negedge clk);
    chk("s3_fall_irq", {31'b0, irq}, 32'h0);
    rd(3'd4, v); chk("s3_fall_ec", v, 32'h0);

    // 4: event and W1C on the same edge; writing 0 is a no-op
    in_port = 4'h4;
    repeat (9) @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 32'h4;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd4, v); chk("s4_set_wins", v, 32'h4);
    wr(3'd4, 32'h0); rd(3'd4, v); chk("s4_w0_noop", v, 32'h4);
    wr(3'd4, 32'h4);
    in_port = 4'h0; repeat (12) @(negedge clk);
    rd(3'd4, v); chk("s4_cleared", v, 32'h0);

    // 5: capture disabled, data still tracks; unused addresses
    wr(3'd3, 32'h3); wr(3'd2, 32'hF); wr(3'd5, 32'hFFFF_FFFF);
    address = 3'd0; in_port = 4'hF;
    repeat (12) @(negedge clk); chk("s5_data_F", readdata, 32'hF);
    in_port = 4'h5;
    repeat (12) @(negedge clk); chk("s5_data_5", readdata, 32'h5);
    in_port = 4'h0;
    repeat (12) @(negedge clk); chk("s5_data_0", readdata, 32'h0);
    chk("s5_irq", {31'b0, irq}, 32'h0);
    rd(3'd4, v); chk("s5_ec", v, 32'h0);
    rd(3'd2, v); chk("s5_mask_kept", v, 32'hF);
    for (int a = 5; a <= 7; a++) begin
      rd(3'(a), v); chk($sformatf("s5_addr%0d", a), v, 32'h0);
    end

    // 6: reset in the middle of a debounce window
    wr(3'd3, 32'h0); wr(3'd2, 32'hF);
    address = 3'd0; in_port = 4'h1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1)  chk("s6_data_rst", readdata, 32'h0);
      if (k == 10) chk("s6_data_e10", readdata, 32'h0);
      if (k == 11) chk("s6_data_e11", readdata, 32'h1);
    end
    rd(3'd2, v); chk("s6_mask_rst", v, 32'h0);
    rd(3'd3, v); chk("s6_mode_rst", v, 32'h0);
    rd(3'd4, v); chk("s6_ec_after", v, 32'h1);
    chk("s6_irq_masked", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
